display_scheduler: RTL and testbench

- Owns the shared 2-digit multiplexed seven-segment display and decides what it shows.
- Two sources compete for it: the game seconds timer (BCD, always present) and the score (BCD, shown for a fixed hold window after each score event).
- Generates the digit-scan timing and drives COM/seven_seg directly.
- Replaces the free-running scan and decode logic inside the timer path.

---
 rtl/display_scheduler.sv | 137 +++++++++++++
 tb/tb_display_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Arbitrates the shared 2-digit seven-segment display between the game timer and
// a held score readout, and generates the digit-scan timing that drives it.
module display_scheduler #(
    parameter int SCAN_DIV = 250000,
    parameter int HOLD_CYC = 100000000,
    parameter int LZ_BLANK = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] timer_bcd,
    input  logic [7:0] score_bcd,
    input  logic       score_req,
    input  logic       blank,
    output logic [0:6] seven_seg,
    output logic [1:0] COM,
    output logic       src,
    output logic       hold_active
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [0:6]    SEG_OFF   = 7'b1111111;

    typedef enum logic [1:0] {
        SHOW_TIMER = 2'd0,
        SHOW_SCORE = 2'd1,
        BLANK      = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] scan_cnt, scan_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [7:0]    score_latch, latch_nxt;
    logic [1:0]    com_nxt;
    logic [0:6]    seg_nxt;

    function automatic logic [0:6] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_OFF;
        endcase
    endfunction

    // Scan timing is independent of the display source and never stops.
    always_comb begin
        scan_nxt = scan_cnt + 1'b1;
        com_nxt  = COM;
        if (scan_cnt == SCAN_LAST) begin
            scan_nxt = '0;
            com_nxt  = ~COM;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        latch_nxt = score_latch;
        if (blank) begin
            state_nxt = BLANK;
            hold_nxt  = '0;
        end else begin
            case (state)
                BLANK: state_nxt = SHOW_TIMER;
                SHOW_TIMER: begin
                    if (score_req) begin
                        state_nxt = SHOW_SCORE;
                        latch_nxt = score_bcd;
                        hold_nxt  = HOLD_LAST;
                    end
                end
                SHOW_SCORE: begin
                    if (score_req) begin
                        latch_nxt = score_bcd;
                        hold_nxt  = HOLD_LAST;
                    end else if (hold_cnt == '0) begin
                        state_nxt = SHOW_TIMER;
                    end else begin
                        hold_nxt = hold_cnt - 1'b1;
                    end
                end
                default: state_nxt = SHOW_TIMER;
            endcase
        end
    end

    // Segments are decoded from post-edge COM/state so digit and enable switch together.
    always_comb begin
        seg_nxt = SEG_OFF;
        case (state_nxt)
            SHOW_TIMER: seg_nxt = com_nxt[1] ? seg_decode(timer_bcd[7:4])
                                             : seg_decode(timer_bcd[3:0]);
            SHOW_SCORE: begin
                if (!com_nxt[1])
                    seg_nxt = seg_decode(latch_nxt[3:0]);
                else if (!(LZ_BLANK != 0 && latch_nxt[7:4] == 4'd0))
                    seg_nxt = seg_decode(latch_nxt[7:4]);
            end
            default: seg_nxt = SEG_OFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= SHOW_TIMER;
            scan_cnt    <= '0;
            hold_cnt    <= '0;
            score_latch <= '0;
            COM         <= 2'b01;
            seven_seg   <= SEG_OFF;
            src         <= 1'b0;
            hold_active <= 1'b0;
        end else begin
            state       <= state_nxt;
            scan_cnt    <= scan_nxt;
            hold_cnt    <= hold_nxt;
            score_latch <= latch_nxt;
            COM         <= com_nxt;
            seven_seg   <= seg_nxt;
            src         <= (state_nxt == SHOW_SCORE);
            hold_active <= (state_nxt == SHOW_SCORE);
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: a cycle-count based reference predicts each
// edge's outputs into a queue, which is popped and compared after the edge.
module tb_display_scheduler;

    localparam int SCAN_DIV = 4;
    localparam int HOLD_CYC = 20;
    localparam int LZ_BLANK = 1;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] timer_bcd = 8'h00;
    logic [7:0] score_bcd = 8'h00;
    logic       score_req = 1'b0;
    logic       blank = 1'b0;
    logic [0:6] seven_seg;
    logic [1:0] COM;
    logic       src;
    logic       hold_active;

    display_scheduler #(
        .SCAN_DIV(SCAN_DIV),
        .HOLD_CYC(HOLD_CYC),
        .LZ_BLANK(LZ_BLANK)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .timer_bcd  (timer_bcd),
        .score_bcd  (score_bcd),
        .score_req  (score_req),
        .blank      (blank),
        .seven_seg  (seven_seg),
        .COM        (COM),
        .src        (src),
        .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] com;
        logic [6:0] seg;
        logic       src;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: edges since reset, last accepted request edge, latched score.
    int         k         = 0;
    int         last_req  = -1000;
    bit         active    = 1'b0;
    bit         prev_blank = 1'b0;
    logic [7:0] latched   = 8'h00;

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        if (d > 4'd9) return 7'b1111111;
        return tbl[d];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    function automatic exp_t predict(input logic c, input logic b, input logic r);
        exp_t e;
        bit   vis;
        if (c) begin
            k = 0; active = 0; prev_blank = 0;
            e.com = 2'b01; e.seg = 7'b1111111; e.src = 1'b0;
            return e;
        end
        k++;
        if (b) active = 0;
        else if (r && !prev_blank) begin
            active = 1; last_req = k; latched = score_bcd;
        end
        vis = active && ((k - last_req) < HOLD_CYC);
        if (!vis) active = 0;
        prev_blank = b;
        e.com = (((k / SCAN_DIV) % 2) != 0) ? 2'b10 : 2'b01;
        e.src = vis;
        if (b)
            e.seg = 7'b1111111;
        else if (vis)
            e.seg = (e.com == 2'b10)
                  ? ((LZ_BLANK != 0 && latched[7:4] == 4'd0) ? 7'b1111111 : dec(latched[7:4]))
                  : dec(latched[3:0]);
        else
            e.seg = (e.com == 2'b10) ? dec(timer_bcd[7:4]) : dec(timer_bcd[3:0]);
        return e;
    endfunction

    task automatic step(input logic c, input logic b, input logic r);
        exp_t e;
        @(negedge clk);
        clear = c; blank = b; score_req = r;
        exp_q.push_back(predict(c, b, r));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("com", {6'd0, COM}, {6'd0, e.com});
        check("seven_seg", {1'b0, seven_seg}, {1'b0, e.seg});
        check("src", {7'd0, src}, {7'd0, e.src});
        check("hold_active", {7'd0, hold_active}, {7'd0, e.src});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and timer scan
        timer_bcd = 8'h37;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(12);

        // Single score event, latched value with leading-zero blank
        score_bcd = 8'h05;
        step(1'b0, 1'b0, 1'b1);
        score_bcd = 8'h09;
        idle(23);

        // Retrigger 15 cycles after the first request
        score_bcd = 8'h34;
        step(1'b0, 1'b0, 1'b1);
        idle(14);
        score_bcd = 8'h12;
        step(1'b0, 1'b0, 1'b1);
        idle(23);

        // Blank aborts the score; request inside the blank window is ignored
        score_bcd = 8'h27;
        step(1'b0, 1'b0, 1'b1);
        idle(4);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, (i == 3));
        idle(25);

        // Clear during SHOW_SCORE while the tens digit is selected
        score_bcd = 8'h61;
        step(1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 2 * SCAN_DIV && ((k / SCAN_DIV) % 2) == 0; g++) idle(1);
        check("clear_at_tens", {7'd0, COM[1]}, 8'h01);
        step(1'b1, 1'b0, 1'b0);
        idle(10);

        // Invalid timer tens digit; request on the edge the hold expires
        timer_bcd = 8'hA3;
        idle(4);
        score_bcd = 8'h48;
        step(1'b0, 1'b0, 1'b1);
        idle(HOLD_CYC - 1);
        score_bcd = 8'h50;
        step(1'b0, 1'b0, 1'b1);
        idle(HOLD_CYC + 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
